// File: rtl/tbird_pkg.sv
// Shared types for the turn-signal lamp scheduler: grant encoding,
// scheduler states and the small helpers that map between them.
package tbird_pkg;

  // Grant currently handed to the light sequencer.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_e;

  // Scheduler handshake states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RUN     = 2'd2,
    HOLDOFF = 2'd3
  } sched_state_e;

  // Switch vector bit positions.
  localparam int SW_LEFT   = 0;
  localparam int SW_RIGHT  = 1;
  localparam int SW_HAZARD = 2;
  localparam int NUM_SW    = 3;

  // Hazard wins, and left+right together is treated as hazard.
  function automatic mode_e arbitrate(input logic [NUM_SW-1:0] sw);
    mode_e m;
    if (sw[SW_HAZARD] || (sw[SW_LEFT] && sw[SW_RIGHT])) m = HAZARD;
    else if (sw[SW_LEFT])                                m = LEFT;
    else if (sw[SW_RIGHT])                               m = RIGHT;
    else                                                 m = NONE;
    return m;
  endfunction

  // One-hot request vector {hazard, right, left} for a grant.
  function automatic logic [NUM_SW-1:0] mode_to_req(input mode_e m);
    logic [NUM_SW-1:0] r;
    r = '0;
    case (m)
      LEFT:    r[SW_LEFT]   = 1'b1;
      RIGHT:   r[SW_RIGHT]  = 1'b1;
      HAZARD:  r[SW_HAZARD] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tbird_debounce.sv
// Switch conditioner: two-flop synchroniser followed by a debouncer that
// only adopts a new level after DB_CYCLES consecutive matching samples.
module tbird_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_b,
  input  logic sw_in,
  output logic sw_db
);

  // Counter must hold DB_CYCLES-1; keep at least one bit when DB_CYCLES is 1.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Next-state: shift the synchroniser, count samples that disagree with
  // the accepted level, and flip the level once the run is long enough.
  always_comb begin
    sync_d = {sync_q[0], sw_in};
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/tbird_lamp_scheduler.sv
// Lamp scheduler: conditions the three switches, generates the lamp step
// tick, arbitrates requests and hands one grant at a time to the light
// sequencer, timing out if the sequencer never acknowledges.
module tbird_lamp_scheduler
  import tbird_pkg::*;
#(
  parameter int TICK_DIV      = 12500000,
  parameter int DB_CYCLES     = 16,
  parameter int GRANT_TIMEOUT = 4
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_hazard,
  input  logic       seq_idle,
  output logic       step_en,
  output logic       req_left,
  output logic       req_right,
  output logic       req_hazard,
  output logic [1:0] mode,
  output logic       grant_err
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int TOW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(GRANT_TIMEOUT - 1);

  logic [NUM_SW-1:0] sw_raw, sw_db, req_vec;
  logic [TW-1:0]     tick_q, tick_d;
  logic [TOW-1:0]    to_q, to_d;
  sched_state_e      state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              err_q, err_d;

  assign sw_raw[SW_LEFT]   = sw_left;
  assign sw_raw[SW_RIGHT]  = sw_right;
  assign sw_raw[SW_HAZARD] = sw_hazard;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    tbird_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clock   (clock),
      .reset_b (reset_b),
      .sw_in   (sw_raw[i]),
      .sw_db   (sw_db[i])
    );
  end

  // Free-running step counter; the pulse is decoded from the count itself
  // so it is low as soon as reset forces the count to zero.
  always_comb begin
    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
  end

  assign step_en = (tick_q == TICK_LAST);

  // Next-state and request outputs; requests are only driven while GRANT.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    to_d    = to_q;
    err_d   = err_q;
    req_vec = '0;
    case (state_q)
      IDLE: begin
        mode_d = NONE;
        to_d   = '0;
        if (step_en && (|sw_db) && seq_idle) begin
          mode_d  = arbitrate(sw_db);
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_vec = mode_to_req(mode_q);
        if (!seq_idle) begin
          state_d = RUN;
        end else if (step_en) begin
          if (to_q == TO_LAST) begin
            err_d   = 1'b1;
            mode_d  = NONE;
            state_d = IDLE;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (seq_idle) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        // Wait a full step so back-to-back flashes keep the step cadence.
        if (step_en) begin
          mode_d  = NONE;
          state_d = IDLE;
        end
      end
      default: begin
        mode_d  = NONE;
        state_d = IDLE;
      end
    endcase
  end

  // Tick counter and scheduler state registers.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      tick_q  <= '0;
      to_q    <= '0;
      state_q <= IDLE;
      mode_q  <= NONE;
      err_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      to_q    <= to_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign req_left   = req_vec[SW_LEFT];
  assign req_right  = req_vec[SW_RIGHT];
  assign req_hazard = req_vec[SW_HAZARD];
  assign mode       = mode_q;
  assign grant_err  = err_q;

endmodule

// File: tb/tb_tbird_lamp_scheduler.sv
// Directed bench for the lamp scheduler with TICK_DIV=8, DB_CYCLES=4,
// GRANT_TIMEOUT=4. Cycle k means the state right after the k-th rising
// edge following reset release; step_en is high after edges 7, 15, 23...
module tb_tbird_lamp_scheduler;

  logic       clock = 1'b0;
  logic       reset_b;
  logic       sw_left, sw_right, sw_hazard;
  logic       seq_idle = 1'b1;
  logic       step_en, req_left, req_right, req_hazard, grant_err;
  logic [1:0] mode;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Sequencer model controls.
  logic model_on      = 1'b0;
  logic seq_force_low = 1'b0;
  int   run_cnt       = 0;

  tbird_lamp_scheduler #(
    .TICK_DIV      (8),
    .DB_CYCLES     (4),
    .GRANT_TIMEOUT (4)
  ) dut (
    .clock      (clock),
    .reset_b    (reset_b),
    .sw_left    (sw_left),
    .sw_right   (sw_right),
    .sw_hazard  (sw_hazard),
    .seq_idle   (seq_idle),
    .step_en    (step_en),
    .req_left   (req_left),
    .req_right  (req_right),
    .req_hazard (req_hazard),
    .mode       (mode),
    .grant_err  (grant_err)
  );

  always #5 clock = ~clock;

  // Sequencer model: leaves idle one cycle after seeing a request, stays
  // busy across two step pulses, then returns idle.
  always @(posedge clock) begin
    if (!model_on) begin
      seq_idle <= !seq_force_low;
      run_cnt  <= 0;
    end else if (seq_idle) begin
      if (req_left || req_right || req_hazard) seq_idle <= 1'b0;
      run_cnt <= 0;
    end else if (step_en) begin
      if (run_cnt == 1) seq_idle <= 1'b1;
      run_cnt <= run_cnt + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requests must never be more than one-hot.
  always @(negedge clock) begin
    if (reset_b === 1'b1)
      chk("req_onehot", (int'(req_left) + int'(req_right) + int'(req_hazard)) <= 1, 1);
  end

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      cyc++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    sw_left = 1'b0; sw_right = 1'b0; sw_hazard = 1'b0;
    model_on = 1'b0; seq_force_low = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_b = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    reset_b = 1'b0;
    sw_left = 1'b0; sw_right = 1'b0; sw_hazard = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_step_en", step_en, 0);
    chk("rst_mode", mode, 0);
    chk("rst_req", {req_hazard, req_right, req_left}, 0);
    chk("rst_err", grant_err, 0);

    // No switches: step pulses every 8 cycles, nothing requested.
    do_reset();
    quiet = 0;
    for (int k = 1; k <= 24; k++) begin
      to_cyc(k);
      chk("step_en_cadence", step_en, (k % 8 == 7) ? 1 : 0);
      if (req_left || req_right || req_hazard || mode != 0) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    // Left held with sequencer model: grant, run, holdoff, regrant.
    do_reset();
    model_on = 1'b1;
    sw_left  = 1'b1;
    to_cyc(7);
    chk("left_pre_grant", mode, 0);
    to_cyc(8);
    chk("left_mode", mode, 1);
    chk("left_req", {req_hazard, req_right, req_left}, 3'b001);
    to_cyc(9);
    chk("left_req_hold", req_left, 1);
    to_cyc(10);
    chk("left_run_req", req_left, 0);
    chk("left_run_mode", mode, 1);
    to_cyc(25);
    chk("left_holdoff_mode", mode, 1);
    chk("left_holdoff_req", req_left, 0);
    to_cyc(32);
    chk("left_back_idle", mode, 0);
    to_cyc(40);
    chk("left_regrant_mode", mode, 1);
    chk("left_regrant_req", req_left, 1);

    // Left and right together -> hazard; switch change mid-grant ignored.
    do_reset();
    sw_left = 1'b1; sw_right = 1'b1;
    to_cyc(8);
    chk("lr_mode", mode, 3);
    chk("lr_req", {req_hazard, req_right, req_left}, 3'b100);
    sw_left = 1'b0;
    to_cyc(20);
    chk("lr_mode_locked", mode, 3);
    chk("lr_req_locked", {req_hazard, req_right, req_left}, 3'b100);

    // Three-cycle glitch on right never grants.
    do_reset();
    sw_right = 1'b1;
    to_cyc(3);
    sw_right = 1'b0;
    quiet = 0;
    for (int k = 4; k <= 40; k++) begin
      to_cyc(k);
      if (req_left || req_right || req_hazard || mode != 0) quiet++;
    end
    chk("glitch_no_grant", quiet, 0);

    // Exactly four-cycle pulse on right is accepted and granted.
    do_reset();
    sw_right = 1'b1;
    to_cyc(4);
    sw_right = 1'b0;
    to_cyc(8);
    chk("pulse4_mode", mode, 2);
    chk("pulse4_req", {req_hazard, req_right, req_left}, 3'b010);

    // Sequencer never leaves idle: timeout after four steps, err sticky.
    do_reset();
    sw_left = 1'b1;
    to_cyc(8);
    chk("to_grant", mode, 1);
    to_cyc(39);
    chk("to_before_mode", mode, 1);
    chk("to_before_err", grant_err, 0);
    to_cyc(40);
    chk("to_err", grant_err, 1);
    chk("to_mode_clr", mode, 0);
    chk("to_req_clr", {req_hazard, req_right, req_left}, 0);
    to_cyc(48);
    chk("to_regrant", mode, 1);
    chk("to_err_sticky", grant_err, 1);

    // Sequencer busy in IDLE: request waits until it is idle.
    do_reset();
    seq_force_low = 1'b1;
    sw_left = 1'b1;
    to_cyc(8);
    chk("busy_no_grant8", mode, 0);
    to_cyc(16);
    chk("busy_no_grant16", mode, 0);
    seq_force_low = 1'b0;
    to_cyc(24);
    chk("busy_then_grant", mode, 1);

    // Reset during RUN drops everything at once.
    do_reset();
    model_on = 1'b1;
    sw_left  = 1'b1;
    to_cyc(12);
    chk("mid_run_mode", mode, 1);
    reset_b = 1'b0;
    #1;
    chk("rst_run_mode", mode, 0);
    chk("rst_run_req", {req_hazard, req_right, req_left}, 0);
    chk("rst_run_step", step_en, 0);
    sw_left  = 1'b0;
    model_on = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_b = 1'b1;
    cyc = 0;
    quiet = 0;
    for (int k = 1; k <= 40; k++) begin
      to_cyc(k);
      if (req_left || req_right || req_hazard || mode != 0) quiet++;
    end
    chk("post_rst_quiet", quiet, 0);
    sw_left = 1'b1;
    to_cyc(48);
    chk("fresh_grant_mode", mode, 1);
    chk("fresh_grant_req", req_left, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tbird_lamp_scheduler.md
TBIRD_LAMP_SCHEDULER -- requirements
Module: tbird_lamp_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 12500000, clock cycles per lamp step (min 2).
REQ-002 Parameter DB_CYCLES, default 16, clock cycles a switch must be stable before its level is accepted (min 1).
REQ-003 Parameter GRANT_TIMEOUT, default 4, step ticks allowed for the sequencer to leave idle after a grant.
REQ-004 clock  input  1  single clock domain, rising-edge.
REQ-005 reset_b  input  1  asynchronous, active-low reset.
REQ-006 sw_left, sw_right, sw_hazard  input  1 each  raw asynchronous switch levels.
REQ-007 seq_idle  input  1  high when the light sequencer is in its all-lamps-off state.
REQ-008 step_en  output  1  one-cycle pulse every TICK_DIV cycles; sequencer advances only on this pulse.
REQ-009 req_left, req_right, req_hazard  output  1 each  one-hot request levels to the sequencer.
REQ-010 mode  output  2  current grant: 0 none, 1 left, 2 right, 3 hazard.
REQ-011 grant_err  output  1  sticky flag, set on grant timeout.

Function
REQ-012 Each sw_* SHALL pass a two-flop synchroniser, then a debouncer accepting a new level only after DB_CYCLES consecutive equal samples.
REQ-013 Tick counter SHALL count 0..TICK_DIV-1 free-running; step_en SHALL be high exactly in the cycle the count equals TICK_DIV-1, then wrap to 0.
REQ-014 Arbitration priority SHALL be: hazard, or left and right both active, -> hazard; else left -> left; else right -> right; else none.
REQ-015 FSM states SHALL be IDLE, GRANT, RUN, HOLDOFF.
REQ-016 IDLE: outputs req_* low, mode 0; on a step_en cycle with any debounced request and seq_idle high, latch arbitration result into mode and go to GRANT.
REQ-017 IDLE with request but seq_idle low SHALL remain in IDLE.
REQ-018 GRANT: exactly the req_* matching mode SHALL be high; when seq_idle is sampled low go to RUN, dropping req_* in the same transition.
REQ-019 GRANT: if GRANT_TIMEOUT step_en pulses occur without seq_idle low, set grant_err, clear mode, go to IDLE.
REQ-020 RUN: req_* low, mode held; when seq_idle returns high go to HOLDOFF.
REQ-021 HOLDOFF: wait for the next step_en, then go to IDLE; a still-active request re-arbitrates there, giving continuous flashing.
REQ-022 Switch changes during GRANT, RUN or HOLDOFF SHALL NOT alter mode; a sequence in progress always completes.
REQ-023 A request present for fewer than DB_CYCLES cycles SHALL never cause a grant.
REQ-024 req_* SHALL be one-hot-or-zero in every cycle; mode SHALL equal the asserted req_* while in GRANT.
REQ-025 grant_err SHALL clear only on reset.

Reset
REQ-026 Asserting reset_b low SHALL immediately force: state IDLE, tick count 0, step_en 0, req_* 0, mode 0, grant_err 0, synchroniser and debounced levels 0.
REQ-027 Reset asserted mid-GRANT or mid-RUN SHALL abandon the grant with no residual request after release.
REQ-028 After reset_b rises, the first step_en SHALL occur TICK_DIV cycles later.

Structure
REQ-029 Package tbird_pkg SHALL hold the mode encoding enum (NONE, LEFT, RIGHT, HAZARD) and the scheduler state enum.
REQ-030 Debounce logic SHALL be one sub-module, tbird_debounce, instantiated three times, parameterised by DB_CYCLES.
REQ-031 Tick counter width SHALL be $clog2(TICK_DIV); timeout counter width $clog2(GRANT_TIMEOUT+1).

Verification (TICK_DIV=8, DB_CYCLES=4, GRANT_TIMEOUT=4)
REQ-032 Reset release, no switches -> step_en on cycles 8, 16, 24; req_* and mode stay 0.
REQ-033 sw_left held, seq_idle model drops 1 cycle after req_left -> mode 1 at the first step_en after debounce; req_left high until seq_idle low; RUN, HOLDOFF, then regrant while held.
REQ-034 sw_left and sw_right rise together -> req_hazard only, mode 3.
REQ-035 sw_right 3-cycle glitch -> no grant, mode stays 0.
REQ-036 seq_idle held high after grant -> after 4 step_en pulses grant_err 1, mode 0, state IDLE.
REQ-037 reset_b pulsed low during RUN -> all outputs 0 in that cycle; no req_* until a fresh debounced request.
